// File: rtl/dcache_wt.sv
// dcache_wt: direct-mapped write-through, no-write-allocate data cache with one-word lines.
// Serves one byte/half/word request at a time; misses and all stores go to memory.
module dcache_wt #(
   parameter int INDEX_W = 7,
   parameter int TAG_W   = 9
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_signed_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        resp_valid_o,
   output logic [31:0] resp_rdata_o,
   output logic        resp_err_o,
   input  logic        flush_i,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic [3:0]  mem_wmask_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i
);
   localparam int LINES = 1 << INDEX_W;

   typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, WRITE, RESP} state_t;

   state_t             state_q, state_d;
   logic [31:0]        addr_q, wdata_q, rdata_q, rdata_d;
   logic [1:0]         size_q;
   logic               sgn_q, we_q, err_q, err_d, flush_pend_q;
   logic [LINES-1:0]   valid_q;
   logic [TAG_W-1:0]   tag_arr [LINES];
   logic [31:0]        data_arr [LINES];
   logic [INDEX_W-1:0] idx;
   logic [TAG_W-1:0]   tag;
   logic [31:0]        cur, wrep, merged;
   logic [3:0]         wmask;
   logic               hit, misal, accept, do_flush;

   function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] a,
                                           input logic [1:0] sz, input logic s);
      logic [31:0] sh;
      sh = w >> {a, 3'b000};
      return sz == 2'b00 ? {{24{s & sh[7]}}, sh[7:0]} :
             sz == 2'b01 ? {{16{s & sh[15]}}, sh[15:0]} : w;
   endfunction

   assign idx      = addr_q[INDEX_W+1:2];
   assign tag      = addr_q[INDEX_W+TAG_W+1:INDEX_W+2];
   assign cur      = data_arr[idx];
   assign hit      = valid_q[idx] && tag_arr[idx] == tag;
   assign misal    = size_q == 2'b11 || (size_q == 2'b01 && addr_q[0]) ||
                     (size_q == 2'b10 && addr_q[1:0] != 2'b00);
   // A pending flush blocks acceptance exactly like a live one
   assign do_flush    = state_q == IDLE && (flush_i || flush_pend_q);
   assign req_ready_o = state_q == IDLE && !flush_i && !flush_pend_q && !rst;
   assign accept      = req_valid_i && req_ready_o;

   assign wrep  = size_q == 2'b00 ? {4{wdata_q[7:0]}} :
                  size_q == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;
   assign wmask = size_q == 2'b00 ? 4'b0001 << addr_q[1:0] :
                  size_q == 2'b01 ? 4'b0011 << addr_q[1:0] : 4'b1111;

   assign mem_req_o    = state_q == REFILL || state_q == WRITE;
   assign mem_we_o     = state_q == WRITE;
   assign mem_addr_o   = mem_req_o ? {addr_q[31:2], 2'b00} : '0;
   assign mem_wdata_o  = mem_we_o ? wrep : '0;
   assign mem_wmask_o  = mem_we_o ? wmask : '0;
   assign resp_valid_o = state_q == RESP;
   assign resp_rdata_o = rdata_q;
   assign resp_err_o   = err_q;

   always_comb begin
      merged = cur;
      for (int i = 0; i < 4; i++)
         if (wmask[i]) merged[8*i +: 8] = wrep[8*i +: 8];
   end

   always_comb begin
      state_d = state_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: if (accept) state_d = LOOKUP;
         LOOKUP: begin
            if (misal) begin
               state_d = RESP;
               err_d   = 1'b1;
               rdata_d = '0;
            end else if (we_q) begin
               state_d = WRITE;
            end else if (hit) begin
               state_d = RESP;
               err_d   = 1'b0;
               rdata_d = extract(cur, addr_q[1:0], size_q, sgn_q);
            end else begin
               state_d = REFILL;
            end
         end
         REFILL: if (mem_ack_i) begin
            state_d = RESP;
            err_d   = 1'b0;
            rdata_d = extract(mem_rdata_i, addr_q[1:0], size_q, sgn_q);
         end
         WRITE: if (mem_ack_i) begin
            state_d = RESP;
            err_d   = 1'b0;
            rdata_d = '0;
         end
         RESP: begin
            state_d = IDLE;
            err_d   = 1'b0;
            rdata_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         valid_q      <= '0;
         flush_pend_q <= 1'b0;
         rdata_q      <= '0;
         err_q        <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         size_q       <= '0;
         sgn_q        <= 1'b0;
         we_q         <= 1'b0;
      end else begin
         state_q <= state_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         if (accept) begin
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            size_q  <= req_size_i;
            sgn_q   <= req_signed_i;
            we_q    <= req_we_i;
         end
         if (do_flush) flush_pend_q <= 1'b0;
         else if (flush_i) flush_pend_q <= 1'b1;
         if (do_flush) valid_q <= '0;
         else if (state_q == REFILL && mem_ack_i) valid_q[idx] <= 1'b1;
      end
   end

   // Tag/data storage carries no reset; rst only suppresses a write in flight
   always_ff @(posedge clk) begin
      if (!rst && state_q == REFILL && mem_ack_i) begin
         tag_arr[idx]  <= tag;
         data_arr[idx] <= mem_rdata_i;
      end else if (!rst && state_q == WRITE && mem_ack_i && hit) begin
         data_arr[idx] <= merged;
      end
   end
endmodule
